// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
//
// Ports:
//   vgaclk      block clock
//   reset_n     asynchronous active-low reset
//   en          pixel enable; all state advances only on cycles with en=1
//   x, y        current pixel column / line
//   hsync       horizontal sync at HSYNC_POL when asserted, delayed PIPE_DLY
//   vsync       vertical sync at VSYNC_POL when asserted, delayed PIPE_DLY
//   sync_b      composite sync to DAC, tied low
//   blank_b     1 during active video, delayed PIPE_DLY
//   line_start  en and x==0 (undelayed)
//   frame_start en and x==0 and y==0 (undelayed)
//   frame_cnt   completed frames, wraps at 2^FCW
module vga_timing_gen #(
  parameter int HACTIVE   = 640,
  parameter int HFP       = 16,
  parameter int HSYN      = 96,
  parameter int HBP       = 48,
  parameter int VACTIVE   = 480,
  parameter int VFP       = 10,
  parameter int VSYN      = 2,
  parameter int VBP       = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIPE_DLY  = 0,
  parameter int CW        = 10,
  parameter int FCW       = 8
) (
  input  logic           vgaclk,
  input  logic           reset_n,
  input  logic           en,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           hsync,
  output logic           vsync,
  output logic           sync_b,
  output logic           blank_b,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);

  localparam int HTOTAL = HACTIVE + HFP + HSYN + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYN + VBP;

  localparam logic [CW-1:0] X_LAST = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(VTOTAL - 1);

  // Sync windows as 32-bit bounds so an end bound equal to the total
  // (zero back porch) cannot wrap in a CW-bit compare.
  localparam logic [31:0] HS_START = 32'(HACTIVE + HFP);
  localparam logic [31:0] HS_END   = 32'(HACTIVE + HFP + HSYN);
  localparam logic [31:0] VS_START = 32'(VACTIVE + VFP);
  localparam logic [31:0] VS_END   = 32'(VACTIVE + VFP + VSYN);
  localparam logic [31:0] H_ACT    = 32'(HACTIVE);
  localparam logic [31:0] V_ACT    = 32'(VACTIVE);

  if ((HTOTAL - 1) >= (2 ** CW) || (VTOTAL - 1) >= (2 ** CW)) begin : g_cw_too_small
    $error("vga_timing_gen: CW=%0d cannot hold HTOTAL-1=%0d / VTOTAL-1=%0d",
           CW, HTOTAL - 1, VTOTAL - 1);
  end

  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY=%0d outside 0..7", PIPE_DLY);
  end

  // Raster counters
  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (en) begin
      if (x == X_LAST) begin
        x <= '0;
        if (y == Y_LAST) begin
          y         <= '0;
          frame_cnt <= frame_cnt + FCW'(1);
        end else begin
          y <= y + CW'(1);
        end
      end else begin
        x <= x + CW'(1);
      end
    end
  end

  // Raw (undelayed) timing, active-high internally
  logic [31:0] xw;
  logic [31:0] yw;
  logic        hs_raw;
  logic        vs_raw;
  logic        bl_raw;

  assign xw     = 32'(x);
  assign yw     = 32'(y);
  assign hs_raw = (xw >= HS_START) && (xw < HS_END);
  assign vs_raw = (yw >= VS_START) && (yw < VS_END);
  assign bl_raw = (xw < H_ACT) && (yw < V_ACT);

  logic hs_q;
  logic vs_q;
  logic bl_q;

  if (PIPE_DLY == 0) begin : g_nodly
    assign hs_q = hs_raw;
    assign vs_q = vs_raw;
    assign bl_q = bl_raw;
  end else begin : g_dly
    // Each stage holds {hs, vs, bl} in active-high form; reset to all-zero
    // means syncs deasserted and blanked until real timing shifts through.
    logic [2:0] stage [PIPE_DLY];

    always_ff @(posedge vgaclk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < PIPE_DLY; i++) begin
          stage[i] <= 3'b000;
        end
      end else if (en) begin
        stage[0] <= {hs_raw, vs_raw, bl_raw};
        for (int i = 1; i < PIPE_DLY; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign {hs_q, vs_q, bl_q} = stage[PIPE_DLY-1];
  end

  assign hsync       = hs_q ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = vs_q ? VSYNC_POL : ~VSYNC_POL;
  assign blank_b     = bl_q;
  assign sync_b      = 1'b0;

  // Strobes track the counters directly, never the delayed path
  assign line_start  = en && (x == '0);
  assign frame_start = en && (x == '0) && (y == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen across four configurations
module tb_vga_timing_gen;

  localparam int ND = 4;
  // dut0: default; dut1: default timing, PIPE_DLY=2; dut2: mid-size, PIPE_DLY=7,
  // positive syncs; dut3: tiny config with FCW=2, CW=3
  localparam int HA [ND] = '{640, 640, 20, 4};
  localparam int HF [ND] = '{16, 16, 3, 1};
  localparam int HS [ND] = '{96, 96, 5, 1};
  localparam int HB [ND] = '{48, 48, 4, 1};
  localparam int VA [ND] = '{480, 480, 10, 2};
  localparam int VF [ND] = '{10, 10, 2, 1};
  localparam int VS [ND] = '{2, 2, 2, 1};
  localparam int VB [ND] = '{33, 33, 3, 1};
  localparam int DL [ND] = '{0, 2, 7, 0};
  localparam int FW [ND] = '{8, 8, 3, 2};
  localparam int HP [ND] = '{0, 0, 1, 0};
  localparam int VP [ND] = '{0, 0, 1, 0};

  logic vgaclk = 1'b0;
  logic reset_n;
  logic en;

  always #5 vgaclk = ~vgaclk;

  int     ncmp  = 0;
  int     nfail = 0;
  longint n     = 0;   // enabled cycles since last reset release

  logic [9:0] x0, y0, x1, y1;
  logic [5:0] x2, y2;
  logic [2:0] x3, y3;
  logic [7:0] f0, f1;
  logic [2:0] f2;
  logic [1:0] f3;
  logic hs [ND];
  logic vs [ND];
  logic sb [ND];
  logic bb [ND];
  logic ls [ND];
  logic fs [ND];

  logic [31:0] ox [ND];
  logic [31:0] oy [ND];
  logic [31:0] of [ND];

  assign ox[0] = 32'(x0); assign oy[0] = 32'(y0); assign of[0] = 32'(f0);
  assign ox[1] = 32'(x1); assign oy[1] = 32'(y1); assign of[1] = 32'(f1);
  assign ox[2] = 32'(x2); assign oy[2] = 32'(y2); assign of[2] = 32'(f2);
  assign ox[3] = 32'(x3); assign oy[3] = 32'(y3); assign of[3] = 32'(f3);

  vga_timing_gen u_dut0 (
    .vgaclk(vgaclk), .reset_n(reset_n), .en(en), .x(x0), .y(y0),
    .hsync(hs[0]), .vsync(vs[0]), .sync_b(sb[0]), .blank_b(bb[0]),
    .line_start(ls[0]), .frame_start(fs[0]), .frame_cnt(f0));

  vga_timing_gen #(.PIPE_DLY(2)) u_dut1 (
    .vgaclk(vgaclk), .reset_n(reset_n), .en(en), .x(x1), .y(y1),
    .hsync(hs[1]), .vsync(vs[1]), .sync_b(sb[1]), .blank_b(bb[1]),
    .line_start(ls[1]), .frame_start(fs[1]), .frame_cnt(f1));

  vga_timing_gen #(
    .HACTIVE(20), .HFP(3), .HSYN(5), .HBP(4),
    .VACTIVE(10), .VFP(2), .VSYN(2), .VBP(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DLY(7), .CW(6), .FCW(3)
  ) u_dut2 (
    .vgaclk(vgaclk), .reset_n(reset_n), .en(en), .x(x2), .y(y2),
    .hsync(hs[2]), .vsync(vs[2]), .sync_b(sb[2]), .blank_b(bb[2]),
    .line_start(ls[2]), .frame_start(fs[2]), .frame_cnt(f2));

  vga_timing_gen #(
    .HACTIVE(4), .HFP(1), .HSYN(1), .HBP(1),
    .VACTIVE(2), .VFP(1), .VSYN(1), .VBP(1),
    .PIPE_DLY(0), .CW(3), .FCW(2)
  ) u_dut3 (
    .vgaclk(vgaclk), .reset_n(reset_n), .en(en), .x(x3), .y(y3),
    .hsync(hs[3]), .vsync(vs[3]), .sync_b(sb[3]), .blank_b(bb[3]),
    .line_start(ls[3]), .frame_start(fs[3]), .frame_cnt(f3));

  // Reference: the whole raster is a function of the enabled-cycle count.
  // Delayed outputs show the raster position DL enabled cycles back, and
  // are inactive until that many cycles have elapsed.
  function automatic void ref_model(input longint cnt, input int d,
                                    output int ex, output int ey, output int ef,
                                    output bit ehs, output bit evs, output bit ebl);
    longint ht, vt, p;
    int     px, py;
    ht  = HA[d] + HF[d] + HS[d] + HB[d];
    vt  = VA[d] + VF[d] + VS[d] + VB[d];
    ex  = int'(cnt % ht);
    ey  = int'((cnt / ht) % vt);
    ef  = int'((cnt / (ht * vt)) % (64'd1 << FW[d]));
    ehs = 1'b0;
    evs = 1'b0;
    ebl = 1'b0;
    if (cnt >= DL[d]) begin
      p   = cnt - DL[d];
      px  = int'(p % ht);
      py  = int'((p / ht) % vt);
      ehs = (px >= HA[d] + HF[d]) && (px < HA[d] + HF[d] + HS[d]);
      evs = (py >= VA[d] + VF[d]) && (py < VA[d] + VF[d] + VS[d]);
      ebl = (px < HA[d]) && (py < VA[d]);
    end
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s dut%0d n=%0d got=%0h exp=%0h", tag, d, n, got, exp);
    end
  endtask

  task automatic check_all(input bit e);
    int ex, ey, ef;
    bit ehs, evs, ebl;
    for (int d = 0; d < ND; d++) begin
      ref_model(n, d, ex, ey, ef, ehs, evs, ebl);
      chk("x",           d, ox[d], 32'(ex));
      chk("y",           d, oy[d], 32'(ey));
      chk("frame_cnt",   d, of[d], 32'(ef));
      chk("hsync",       d, 32'(hs[d]), 32'(ehs ? HP[d] : 1 - HP[d]));
      chk("vsync",       d, 32'(vs[d]), 32'(evs ? VP[d] : 1 - VP[d]));
      chk("blank_b",     d, 32'(bb[d]), 32'(ebl));
      chk("sync_b",      d, 32'(sb[d]), 32'(0));
      chk("line_start",  d, 32'(ls[d]), 32'(e && ex == 0));
      chk("frame_start", d, 32'(fs[d]), 32'(e && ex == 0 && ey == 0));
    end
  endtask

  // Drive en away from the rising edge, check, then let the edge happen
  task automatic step(input bit e);
    @(negedge vgaclk);
    en = e;
    #1;
    check_all(e);
    @(posedge vgaclk);
    if (reset_n && e) n++;
  endtask

  // Reset pulse entirely inside the clock-low phase: any change seen must
  // come from the asynchronous path
  task automatic async_reset();
    @(negedge vgaclk);
    #2;
    en      = 1'b0;
    reset_n = 1'b0;
    n       = 0;
    #1;
    check_all(1'b0);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    repeat (3) step(1'b0);
    step(1'b1);              // held in reset; strobe still follows en at x==0
    #2;
    reset_n = 1'b1;

    repeat (2000) step(1'b1);
    repeat (1800) begin
      step(1'b0);
      step(1'b1);
    end

    async_reset();
    repeat (4000) step($urandom_range(0, 3) != 0);

    async_reset();
    repeat (1500) step(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
